// File: rtl/robot_pkg.sv
// Shared definitions for the robot movement path: command codes, button bit
// positions and the scheduler FSM state type.
package robot_pkg;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_UP    = 3'd1;
  localparam logic [2:0] CMD_DOWN  = 3'd2;
  localparam logic [2:0] CMD_LEFT  = 3'd3;
  localparam logic [2:0] CMD_RIGHT = 3'd4;
  localparam logic [2:0] CMD_CLEAN = 3'd5;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_AB    = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } sched_state_e;

  // Highest-priority pressed button mapped to its command code.
  function automatic logic [2:0] btn_to_cmd(input logic [4:0] b);
    logic [2:0] c;
    c = CMD_NOP;
    if (b[BTN_UP])         c = CMD_UP;
    else if (b[BTN_DOWN])  c = CMD_DOWN;
    else if (b[BTN_LEFT])  c = CMD_LEFT;
    else if (b[BTN_RIGHT]) c = CMD_RIGHT;
    else if (b[BTN_AB])    c = CMD_CLEAN;
    return c;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Two-flop vsync synchroniser with falling-edge detector; one-cycle strobe
// per frame.
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vs,
  output logic tick
);

  logic vs_q1;
  logic vs_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q1 <= 1'b1;
      vs_q2 <= 1'b1;
    end else begin
      vs_q1 <= vs;
      vs_q2 <= vs_q1;
    end
  end

  assign tick = vs_q2 & ~vs_q1;

endmodule

// File: rtl/move_scheduler.sv
// Frame-paced command scheduler: picks manual (gamepad) or autonomous steps
// and offers them to world over a valid/ready handshake.
module move_scheduler
  import robot_pkg::*;
#(
  parameter int unsigned AUTO_DIV      = 4,
  parameter int unsigned REPEAT_FRAMES = 8
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        mode,
  input  logic        vga_vs,
  input  logic [10:0] buttons,
  input  logic        auto_req,
  input  logic [2:0]  auto_cmd,
  output logic        auto_ack,
  output logic        cmd_valid,
  output logic [2:0]  cmd,
  input  logic        cmd_ready,
  output logic        cmd_src,
  output logic        frame_tick
);

  localparam logic [7:0] DIV_LAST = 8'(AUTO_DIV - 1);
  localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);

  sched_state_e state_q, state_d;
  logic [7:0]   div_q, div_d;
  logic [7:0]   rep_q, rep_d;
  logic [4:0]   prev_q, prev_d;
  logic [4:0]   arm_q, arm_d;
  logic         mode_q;
  logic         valid_d, ack_d, src_d;
  logic [2:0]   cmd_d;

  logic [4:0]   btn, sel, fresh;
  logic [2:0]   sel_cmd;
  logic         mode_chg;
  logic         unused_btn;

  frame_tick_gen u_tick (
    .clk   (clock_50),
    .reset (reset),
    .vs    (vga_vs),
    .tick  (frame_tick)
  );

  assign btn        = buttons[4:0];
  assign sel        = btn & (~btn + 5'd1);
  assign fresh      = btn & ~prev_q;
  assign sel_cmd    = btn_to_cmd(btn);
  assign mode_chg   = (mode != mode_q);
  assign unused_btn = ^buttons[10:5];

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    rep_d   = rep_q;
    prev_d  = prev_q;
    arm_d   = arm_q;
    valid_d = cmd_valid;
    cmd_d   = cmd;
    src_d   = cmd_src;
    ack_d   = 1'b0;

    if (mode_chg) begin
      div_d  = '0;
      rep_d  = '0;
      prev_d = btn;
      arm_d  = '0;
    end

    unique case (state_q)
      ST_ISSUE: begin
        if (cmd_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        if (frame_tick && !mode_chg) begin
          if (!mode) begin
            prev_d = btn;
            if (btn == '0) begin
              rep_d = '0;
              arm_d = '0;
            end else if ((sel & fresh) != '0) begin
              valid_d = 1'b1;
              cmd_d   = sel_cmd;
              src_d   = 1'b0;
              state_d = ST_ISSUE;
              rep_d   = '0;
              arm_d   = sel[BTN_AB] ? '0 : sel;
            // Repeat only the direction that was itself issued on a fresh
            // press, so a button held across a mode switch stays silent.
            end else if (sel == arm_q) begin
              if (rep_q == REP_LAST) begin
                valid_d = 1'b1;
                cmd_d   = sel_cmd;
                src_d   = 1'b0;
                state_d = ST_ISSUE;
                rep_d   = '0;
              end else begin
                rep_d = rep_q + 8'd1;
              end
            end else begin
              rep_d = '0;
              arm_d = '0;
            end
          end else begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              if (auto_req) begin
                ack_d = 1'b1;
                if (auto_cmd >= CMD_UP && auto_cmd <= CMD_CLEAN) begin
                  valid_d = 1'b1;
                  cmd_d   = auto_cmd;
                  src_d   = 1'b1;
                  state_d = ST_ISSUE;
                end
              end
            end else begin
              div_d = div_q + 8'd1;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      rep_q     <= '0;
      prev_q    <= '0;
      arm_q     <= '0;
      mode_q    <= mode;
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      cmd_src   <= 1'b0;
      auto_ack  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rep_q     <= rep_d;
      prev_q    <= prev_d;
      arm_q     <= arm_d;
      mode_q    <= mode;
      cmd_valid <= valid_d;
      cmd       <= cmd_d;
      cmd_src   <= src_d;
      auto_ack  <= ack_d;
    end
  end

endmodule

// File: tb/tb_move_scheduler.sv
// Self-checking bench for move_scheduler: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_move_scheduler;

  localparam int AUTO_DIV      = 4;
  localparam int REPEAT_FRAMES = 8;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b0;
  logic        vga_vs = 1'b1;
  logic [10:0] buttons = '0;
  logic        auto_req = 1'b0;
  logic [2:0]  auto_cmd = '0;
  logic        cmd_ready = 1'b1;
  logic        auto_ack, cmd_valid, cmd_src, frame_tick;
  logic [2:0]  cmd;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (frame-level)
  bit         m_busy = 0;
  logic [2:0] m_cmd = '0;
  bit         m_src = 0;
  logic [4:0] m_prev = '0;
  int         m_arm = -1;
  int         m_held = 0;
  int         m_auto = 0;
  int         m_accepts = 0;
  int         m_acks = 0;

  // observed handshake events
  int         acc_seen = 0;
  int         ack_seen = 0;
  bit         pend = 0;
  logic [2:0] pcmd = '0;

  move_scheduler #(.AUTO_DIV(AUTO_DIV), .REPEAT_FRAMES(REPEAT_FRAMES)) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .mode       (mode),
    .vga_vs     (vga_vs),
    .buttons    (buttons),
    .auto_req   (auto_req),
    .auto_cmd   (auto_cmd),
    .auto_ack   (auto_ack),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_ready  (cmd_ready),
    .cmd_src    (cmd_src),
    .frame_tick (frame_tick)
  );

  always #10 clock_50 = ~clock_50;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock_50) begin
    pend = cmd_valid && !cmd_ready && !reset;
    pcmd = cmd;
    if (!reset && cmd_valid && cmd_ready) acc_seen++;
    if (!reset && auto_ack) ack_seen++;
  end

  always @(negedge clock_50) begin
    if (pend) begin
      check("hold_valid", cmd_valid, 1);
      check("hold_cmd", cmd, pcmd);
    end
  end

  function automatic void model_issue(input logic [2:0] c, input bit s);
    m_busy = 1;
    m_cmd  = c;
    m_src  = s;
  endfunction

  task automatic model_step(output bit ack_e);
    logic [4:0] b;
    int top;
    ack_e = 0;
    if (m_busy) return;
    if (!mode) begin
      b   = buttons[4:0];
      top = -1;
      for (int i = 0; i < 5; i++) if (b[i] && top < 0) top = i;
      if (top < 0) begin
        m_arm = -1;
      end else if (!m_prev[top]) begin
        model_issue(3'(top + 1), 0);
        m_arm  = (top == 4) ? -1 : top;
        m_held = 0;
      end else if (top == m_arm) begin
        m_held++;
        if (m_held == REPEAT_FRAMES) begin
          model_issue(3'(top + 1), 0);
          m_held = 0;
        end
      end else begin
        m_arm = -1;
      end
      m_prev = b;
    end else begin
      m_auto++;
      if ((m_auto % AUTO_DIV) == 0 && auto_req) begin
        ack_e = 1;
        m_acks++;
        if (auto_cmd >= 3'd1 && auto_cmd <= 3'd5) model_issue(auto_cmd, 1);
      end
    end
  endtask

  task automatic tick_frame();
    bit ack_e;
    repeat ($urandom_range(20, 8)) @(negedge clock_50);
    vga_vs = 1'b0;
    @(posedge clock_50); #1;
    check("tick_high", frame_tick, 1);
    check("valid_pre", cmd_valid, m_busy);
    model_step(ack_e);
    @(posedge clock_50); #1;
    check("tick_low", frame_tick, 0);
    check("ack", auto_ack, ack_e);
    check("valid", cmd_valid, m_busy);
    if (m_busy) check("cmd", cmd, m_cmd);
    check("src", cmd_src, m_src);
    @(posedge clock_50); #1;
    check("ack_end", auto_ack, 0);
    if (m_busy && cmd_ready) begin
      check("accepted", cmd_valid, 0);
      m_busy = 0;
      m_accepts++;
    end
    @(negedge clock_50);
    vga_vs = 1'b1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) tick_frame();
  endtask

  task automatic set_buttons(input logic [10:0] v);
    @(negedge clock_50);
    buttons = v;
  endtask

  task automatic set_mode(input logic m);
    @(negedge clock_50);
    mode   = m;
    m_prev = buttons[4:0];
    m_held = 0;
    m_auto = 0;
    m_arm  = -1;
    @(negedge clock_50);
  endtask

  task automatic release_ready();
    @(negedge clock_50);
    cmd_ready = 1'b1;
    @(posedge clock_50); #1;
    check("release", cmd_valid, 0);
    m_busy = 0;
    m_accepts++;
  endtask

  task automatic do_reset();
    @(negedge clock_50);
    reset = 1'b1;
    @(posedge clock_50); #1;
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_ack", auto_ack, 0);
    check("rst_src", cmd_src, 0);
    check("rst_tick", frame_tick, 0);
    @(negedge clock_50);
    reset  = 1'b0;
    m_busy = 0;
    m_cmd  = '0;
    m_src  = 0;
    m_prev = '0;
    m_arm  = -1;
    m_held = 0;
    m_auto = 0;
  endtask

  initial begin
    do_reset();

    // manual up: issue, then repeat every REPEAT_FRAMES frames
    set_buttons(11'h001);
    frames(20);
    set_buttons(11'h000);
    frames(2);

    // left + clean: left wins and repeats, clean never issued
    set_buttons(11'h014);
    frames(20);
    set_buttons(11'h000);
    frames(1);

    // auto mode: valid step, illegal code, no request
    set_mode(1'b1);
    auto_req = 1'b1;
    auto_cmd = 3'd4;
    frames(13);
    auto_cmd = 3'd6;
    frames(8);
    auto_req = 1'b0;
    frames(4);

    // stall: ready low across three frames, then one acceptance
    set_mode(1'b0);
    frames(1);
    set_buttons(11'h002);
    cmd_ready = 1'b0;
    frames(4);
    release_ready();
    set_buttons(11'h000);
    frames(1);

    // right held across auto->manual switch stays silent until re-pressed
    set_buttons(11'h008);
    set_mode(1'b1);
    frames(3);
    set_mode(1'b0);
    frames(20);
    set_buttons(11'h000);
    frames(1);
    set_buttons(11'h008);
    frames(2);
    set_buttons(11'h000);
    frames(1);

    // reset during ISSUE drops the command; next tick is a first frame
    cmd_ready = 1'b0;
    set_buttons(11'h001);
    frames(1);
    do_reset();
    cmd_ready = 1'b1;
    frames(2);

    // randomized traffic
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(5, 0) == 0)
        set_buttons({6'($urandom), 5'($urandom)});
      if ($urandom_range(9, 0) == 0) set_mode(~mode);
      auto_req = ($urandom_range(3, 0) != 0);
      auto_cmd = 3'($urandom);
      if (m_busy) begin
        if ($urandom_range(1, 0) == 0) release_ready();
      end else begin
        cmd_ready = ($urandom_range(3, 0) != 0);
      end
      tick_frame();
    end
    if (m_busy) release_ready();

    repeat (3) @(negedge clock_50);
    check("accept_count", acc_seen, m_accepts);
    check("ack_count", ack_seen, m_acks);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
